// File: rtl/car_pkg.sv
// Shared encodings for the line-following car: motion modes, tracker codes and the
// duty ramp helper reused by the motor driver.
package car_pkg;

    typedef enum logic [2:0] {
        ModeIdle    = 3'd0,
        ModeFwd     = 3'd1,
        ModeLeft    = 3'd2,
        ModeRight   = 3'd3,
        ModeSearch  = 3'd4,
        ModeLost    = 3'd5,
        ModeBlocked = 3'd6
    } mode_e;

    localparam logic [1:0] TRK_LOST  = 2'b00;
    localparam logic [1:0] TRK_LEFT  = 2'b01;
    localparam logic [1:0] TRK_RIGHT = 2'b10;
    localparam logic [1:0] TRK_FWD   = 2'b11;

    // Move cur toward tgt by at most step, never overshooting.
    function automatic int unsigned ramp_toward(input int unsigned cur, input int unsigned tgt,
                                                input int unsigned step);
        int unsigned diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            return cur + ((diff > step) ? step : diff);
        end
        diff = cur - tgt;
        return cur - ((diff > step) ? step : diff);
    endfunction

endpackage

// File: rtl/track_debouncer.sv
// Accepts a new 2-bit tracker code only once it has been stable for DEBOUNCE cycles.
module track_debouncer #(
    parameter int unsigned DEBOUNCE = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] in,
    output logic [1:0] out
);
    localparam int unsigned CW = $clog2(DEBOUNCE);

    logic [1:0]    r_cand;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cand <= 2'b00;
            r_cnt  <= '0;
            r_out  <= 2'b00;
        end else if (in != r_cand) begin
            r_cand <= in;
            r_cnt  <= '0;
        end else if (r_cnt != CW'(DEBOUNCE - 1)) begin
            r_cnt <= r_cnt + CW'(1);
            // Accept on the edge where the count lands on DEBOUNCE-1.
            if (r_cnt == CW'(DEBOUNCE - 2)) r_out <= r_cand;
        end
    end

    assign out = r_out;

endmodule

// File: rtl/motion_sequencer.sv
// Line-following motion controller: debounced tracker code drives a mode FSM, each wheel's
// duty ramps toward a mode target (reversing only through zero) and feeds a shared PWM.
module motion_sequencer
    import car_pkg::*;
#(
    parameter int unsigned DEBOUNCE       = 1000,
    parameter int unsigned SEARCH_TIMEOUT = 50_000_000,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned RAMP_DIV       = 256,
    parameter int unsigned RAMP_STEP      = 16,
    parameter int unsigned FWD_DUTY       = 200,
    parameter int unsigned TURN_OUT_DUTY  = 160,
    parameter int unsigned TURN_IN_DUTY   = 40,
    parameter int unsigned SEARCH_DUTY    = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] track_state,
    input  logic       enable,
    input  logic       obstacle,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic       left_dir,
    output logic       right_dir,
    output logic [2:0] mode
);
    localparam int unsigned SW = $clog2(SEARCH_TIMEOUT + 1);
    localparam int unsigned RW = $clog2(RAMP_DIV + 1);

    logic [1:0]          w_code;
    mode_e               r_mode;
    logic [SW-1:0]       r_search_cnt;
    logic                r_last_right;
    logic [RW-1:0]       r_ramp_cnt;
    logic                w_tick;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_left_duty, r_right_duty;
    logic                r_left_dir, r_right_dir;
    logic                r_left_pwm, r_right_pwm;
    logic [PWM_BITS-1:0] w_left_tgt_duty, w_right_tgt_duty;
    logic                w_left_tgt_dir, w_right_tgt_dir;

    track_debouncer #(.DEBOUNCE(DEBOUNCE)) u_debouncer (
        .clk   (clk),
        .reset (reset),
        .in    (track_state),
        .out   (w_code)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode       <= ModeIdle;
            r_search_cnt <= '0;
            r_last_right <= 1'b0;
        end else if (obstacle) begin
            r_mode <= ModeBlocked;
        end else if (!enable) begin
            r_mode <= ModeIdle;
        end else if (r_mode != ModeLost) begin
            case (w_code)
                TRK_FWD: r_mode <= ModeFwd;
                TRK_LEFT: begin
                    r_mode       <= ModeLeft;
                    r_last_right <= 1'b0;
                end
                TRK_RIGHT: begin
                    r_mode       <= ModeRight;
                    r_last_right <= 1'b1;
                end
                default: begin
                    if (r_mode != ModeSearch) begin
                        r_mode       <= ModeSearch;
                        r_search_cnt <= '0;
                    end else if (r_search_cnt == SW'(SEARCH_TIMEOUT - 1)) begin
                        r_mode <= ModeLost;
                    end else begin
                        r_search_cnt <= r_search_cnt + SW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_left_tgt_dir   = 1'b1;
        w_right_tgt_dir  = 1'b1;
        w_left_tgt_duty  = '0;
        w_right_tgt_duty = '0;
        case (r_mode)
            ModeFwd: begin
                w_left_tgt_duty  = PWM_BITS'(FWD_DUTY);
                w_right_tgt_duty = PWM_BITS'(FWD_DUTY);
            end
            ModeLeft: begin
                w_left_tgt_duty  = PWM_BITS'(TURN_IN_DUTY);
                w_right_tgt_duty = PWM_BITS'(TURN_OUT_DUTY);
            end
            ModeRight: begin
                w_left_tgt_duty  = PWM_BITS'(TURN_OUT_DUTY);
                w_right_tgt_duty = PWM_BITS'(TURN_IN_DUTY);
            end
            ModeSearch: begin
                // Spin in place toward the side the line was last seen on.
                w_left_tgt_duty  = PWM_BITS'(SEARCH_DUTY);
                w_right_tgt_duty = PWM_BITS'(SEARCH_DUTY);
                w_left_tgt_dir   = r_last_right;
                w_right_tgt_dir  = !r_last_right;
            end
            default: ;
        endcase
    end

    assign w_tick = (r_ramp_cnt == RW'(RAMP_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ramp_cnt <= '0;
        else       r_ramp_cnt <= w_tick ? '0 : r_ramp_cnt + RW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_left_duty <= '0;
            r_left_dir  <= 1'b1;
        end else if (obstacle) begin
            r_left_duty <= '0;
        end else if (w_tick) begin
            if (w_left_tgt_dir != r_left_dir) begin
                if (r_left_duty != '0)
                    r_left_duty <= PWM_BITS'(ramp_toward(32'(r_left_duty), 0, RAMP_STEP));
                else
                    r_left_dir <= w_left_tgt_dir;
            end else begin
                r_left_duty <= PWM_BITS'(ramp_toward(32'(r_left_duty), 32'(w_left_tgt_duty),
                                                     RAMP_STEP));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_right_duty <= '0;
            r_right_dir  <= 1'b1;
        end else if (obstacle) begin
            r_right_duty <= '0;
        end else if (w_tick) begin
            if (w_right_tgt_dir != r_right_dir) begin
                if (r_right_duty != '0)
                    r_right_duty <= PWM_BITS'(ramp_toward(32'(r_right_duty), 0, RAMP_STEP));
                else
                    r_right_dir <= w_right_tgt_dir;
            end else begin
                r_right_duty <= PWM_BITS'(ramp_toward(32'(r_right_duty), 32'(w_right_tgt_duty),
                                                      RAMP_STEP));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt   <= '0;
            r_left_pwm  <= 1'b0;
            r_right_pwm <= 1'b0;
        end else begin
            r_pwm_cnt   <= r_pwm_cnt + PWM_BITS'(1);
            r_left_pwm  <= (r_pwm_cnt < r_left_duty);
            r_right_pwm <= (r_pwm_cnt < r_right_duty);
        end
    end

    assign left_pwm  = r_left_pwm;
    assign right_pwm = r_right_pwm;
    assign left_dir  = r_left_dir;
    assign right_dir = r_right_dir;
    assign mode      = r_mode;

endmodule

// File: tb/tb_motion_sequencer.sv
// Scoreboard bench for motion_sequencer: expectations are queued with each stimulus step and
// popped as the DUT settles after the stepped edges.
module tb_motion_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] track_state = 2'b11;
    logic       enable = 1'b0;
    logic       obstacle = 1'b0;
    logic       left_pwm, right_pwm, left_dir, right_dir;
    logic [2:0] mode;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   flip_err = 0;
    int   dir_bad;
    int   hi;
    logic prev_ldir = 1'b1;
    logic prev_rdir = 1'b1;

    motion_sequencer #(
        .DEBOUNCE       (4),
        .SEARCH_TIMEOUT (100),
        .PWM_BITS       (8),
        .RAMP_DIV       (4),
        .RAMP_STEP      (16),
        .FWD_DUTY       (128)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .track_state (track_state),
        .enable      (enable),
        .obstacle    (obstacle),
        .left_pwm    (left_pwm),
        .right_pwm   (right_pwm),
        .left_dir    (left_dir),
        .right_dir   (right_dir),
        .mode        (mode)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic compare(input int got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", sb_q.size(), 1);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, got, e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A direction change is only legal while that wheel's duty is zero.
    always @(negedge clk) begin
        if (reset) begin
            prev_ldir = 1'b1;
            prev_rdir = 1'b1;
        end else begin
            if (left_dir != prev_ldir && dut.r_left_duty != 0) flip_err++;
            if (right_dir != prev_rdir && dut.r_right_duty != 0) flip_err++;
            prev_ldir = left_dir;
            prev_rdir = right_dir;
        end
    end

    initial begin
        // Reset values
        expect_val("rst_mode", 0);
        expect_val("rst_lpwm", 0);
        expect_val("rst_rpwm", 0);
        expect_val("rst_ldir", 1);
        expect_val("rst_rdir", 1);
        step(2);
        compare(mode);
        compare(left_pwm);
        compare(right_pwm);
        compare(left_dir);
        compare(right_dir);

        // Startup into FWD; enable raised just before edge 5
        reset = 1'b0;
        expect_val("idle_edge4", 0);
        step(4);
        compare(mode);
        enable = 1'b1;
        expect_val("fwd_edge5", 1);
        step(1);
        compare(mode);
        dir_bad = 0;
        expect_val("ramp_edge35_l", 112);
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (!left_dir || !right_dir) dir_bad++;
        end
        compare(int'(dut.r_left_duty));
        expect_val("ramp_edge36_l", 128);
        expect_val("ramp_edge36_r", 128);
        step(1);
        compare(int'(dut.r_left_duty));
        compare(int'(dut.r_right_duty));
        expect_val("fwd_no_overshoot", 128);
        step(4);
        compare(int'(dut.r_right_duty));
        expect_val("fwd_dirs_forward", 0);
        compare(dir_bad);
        expect_val("fwd_pwm_highs", 128);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            hi += int'(left_pwm);
        end
        compare(hi);

        // Glitch rejection, then a real left turn
        expect_val("glitch1_mode", 1);
        track_state = 2'b01;
        step(1);
        track_state = 2'b11;
        step(8);
        compare(mode);
        expect_val("glitch3_mode", 1);
        track_state = 2'b01;
        step(3);
        track_state = 2'b11;
        step(8);
        compare(mode);
        expect_val("turn_edge4_mode", 1);
        expect_val("turn_edge5_mode", 2);
        track_state = 2'b01;
        step(4);
        compare(mode);
        step(1);
        compare(mode);
        expect_val("left_duty_l", 40);
        expect_val("left_duty_r", 160);
        step(40);
        compare(int'(dut.r_left_duty));
        compare(int'(dut.r_right_duty));

        // Lost line after a left turn: spin left, then time out
        expect_val("search_edge4_mode", 2);
        expect_val("search_edge5_mode", 4);
        track_state = 2'b00;
        step(4);
        compare(mode);
        step(1);
        compare(mode);
        expect_val("search_ldir", 0);
        expect_val("search_lduty", 100);
        expect_val("search_rdir", 1);
        expect_val("search_rduty", 100);
        step(60);
        compare(left_dir);
        compare(int'(dut.r_left_duty));
        compare(right_dir);
        compare(int'(dut.r_right_duty));
        expect_val("search_99_mode", 4);
        expect_val("search_100_mode", 5);
        step(39);
        compare(mode);
        step(1);
        compare(mode);

        // LOST: wheels wind down and the line reappearing is ignored
        expect_val("lost_lduty", 0);
        expect_val("lost_rduty", 0);
        expect_val("lost_ldir", 1);
        step(60);
        compare(int'(dut.r_left_duty));
        compare(int'(dut.r_right_duty));
        compare(left_dir);
        expect_val("lost_sticky", 5);
        track_state = 2'b11;
        step(10);
        compare(mode);
        expect_val("lost_to_idle", 0);
        enable = 1'b0;
        step(1);
        compare(mode);

        // Obstacle stop during FWD
        expect_val("refwd_mode", 1);
        enable = 1'b1;
        step(1);
        compare(mode);
        expect_val("refwd_duty", 128);
        step(40);
        compare(int'(dut.r_left_duty));
        expect_val("blocked_mode", 6);
        expect_val("blocked_lduty", 0);
        expect_val("blocked_rduty", 0);
        obstacle = 1'b1;
        step(1);
        compare(mode);
        compare(int'(dut.r_left_duty));
        compare(int'(dut.r_right_duty));
        expect_val("blocked_pwm_highs", 0);
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            hi += int'(left_pwm) + int'(right_pwm);
        end
        compare(hi);
        expect_val("unblock_mode", 1);
        expect_val("unblock_duty", 0);
        obstacle = 1'b0;
        step(1);
        compare(mode);
        compare(int'(dut.r_left_duty));

        // Right turn, search toward right, then asynchronous reset mid-ramp
        expect_val("right_mode", 3);
        track_state = 2'b10;
        step(5);
        compare(mode);
        expect_val("rsearch_mode", 4);
        track_state = 2'b00;
        step(5);
        compare(mode);
        expect_val("rsearch_rdir", 0);
        expect_val("rsearch_ldir", 1);
        step(40);
        compare(right_dir);
        compare(left_dir);
        expect_val("async_rst_mode", 0);
        expect_val("async_rst_lpwm", 0);
        expect_val("async_rst_rpwm", 0);
        expect_val("async_rst_ldir", 1);
        expect_val("async_rst_rdir", 1);
        expect_val("async_rst_rduty", 0);
        #2;
        reset = 1'b1;
        #1;
        compare(mode);
        compare(left_pwm);
        compare(right_pwm);
        compare(left_dir);
        compare(right_dir);
        compare(int'(dut.r_right_duty));
        step(1);
        reset = 1'b0;

        // After reset: last_turn is left and the search timer starts from zero
        expect_val("post_rst_ldir", 0);
        expect_val("post_rst_rdir", 1);
        step(60);
        compare(left_dir);
        compare(right_dir);
        expect_val("post_rst_search_100", 4);
        expect_val("post_rst_lost_101", 5);
        step(40);
        compare(mode);
        step(1);
        compare(mode);

        check_eq("flip_through_zero", flip_err, 0);
        check_eq("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
